// File: rtl/fft_pkg.sv
// Shared FFT definitions: precision-dependent widths, fixed-point pi
// constants, float exponent offsets and the angle generator FSM states.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // round(pi * 2^FRAC) for Q2.30 and Q2.62
  localparam logic [31:0] PI_Q_SP = 32'hC90F_DAA2;
  localparam logic [63:0] PI_Q_DP = 64'hC90F_DAA2_2168_C235;

  // bias - FRAC: converts a leading-one bit position into a biased exponent
  localparam int EXP_OFF_SP = 32'd97;
  localparam int EXP_OFF_DP = 32'd961;

  function automatic int fp_size(input bit dbl);
    return dbl ? 32'd64 : 32'd32;
  endfunction

  function automatic int fp_frac(input bit dbl);
    return fp_size(dbl) - 32'd2;
  endfunction

  function automatic int fp_bias(input bit dbl);
    return dbl ? 32'd1023 : 32'd127;
  endfunction

  function automatic int fp_exp_w(input bit dbl);
    return dbl ? 32'd11 : 32'd8;
  endfunction

  function automatic int fp_mant_w(input bit dbl);
    return dbl ? 32'd52 : 32'd23;
  endfunction

  function automatic int fp_exp_off(input bit dbl);
    return dbl ? EXP_OFF_DP : EXP_OFF_SP;
  endfunction

  function automatic logic [63:0] pi_q(input bit dbl);
    return dbl ? PI_Q_DP : {32'h0000_0000, PI_Q_SP};
  endfunction

endpackage

// File: rtl/fix2float.sv
// Unsigned Q2.FRAC to IEEE-754 conversion with the sign forced negative.
// Purely combinational: leading-one search, left-normalise, truncate.
module fix2float
  import fft_pkg::*;
#(
  parameter bit DOUBLE = 1'b0,
  localparam int W = fp_size(DOUBLE)
) (
  input  logic [W-1:0] fix,
  output logic [W-1:0] flt
);

  localparam int EW   = fp_exp_w(DOUBLE);
  localparam int MW   = fp_mant_w(DOUBLE);
  localparam int EOFF = fp_exp_off(DOUBLE);

  logic [6:0]    lead_s;
  logic          found_s;
  logic [W-1:0]  shifted_s;
  logic [EW-1:0] exp_s;

  // Find the leading one, shift it to the MSB and pack sign/exponent/mantissa
  always_comb begin
    lead_s  = 7'd0;
    found_s = 1'b0;
    for (int i = 0; i < W; i++) begin
      lead_s  = fix[i] ? 7'(i) : lead_s;
      found_s = found_s | fix[i];
    end
    shifted_s = fix << (7'(W - 1) - lead_s);
    exp_s     = EW'(32'(lead_s) + EOFF);
    if (found_s) begin
      // the hidden one sits at bit W-1; the mantissa is the bits just below it
      flt = {1'b1, exp_s, shifted_s[W-2 -: MW]};
    end else begin
      flt = '0;
    end
  end

endmodule

// File: rtl/twiddle_angle_gen.sv
// Emits theta_k = -2*pi*k/N for k = 0..N/2-1 as IEEE floats over a
// valid/ready interface. Phase is accumulated in Q2.FRAC and converted
// to float in a two-stage pipeline that freezes under backpressure.
module twiddle_angle_gen
  import fft_pkg::*;
#(
  parameter bit DOUBLE = 1'b0,
  parameter int LOG2N  = 4,
  localparam int SIZE  = fp_size(DOUBLE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [SIZE-1:0]   theta,
  output logic [LOG2N-2:0]  k_idx,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic              done
);

  localparam int KW = LOG2N - 1;
  localparam logic [KW-1:0]   K_LAST = {KW{1'b1}};
  localparam logic [SIZE-1:0] STEP_Q = SIZE'(pi_q(DOUBLE) >> (LOG2N - 1));

  fsm_state_e      state_r;
  logic            busy_r, done_r, feed_r;
  logic [KW-1:0]   k_r;
  logic [SIZE-1:0] phase_r;

  logic            s1_valid_r, s1_last_r;
  logic [KW-1:0]   s1_k_r;
  logic [SIZE-1:0] s1_phase_r;

  logic            valid_r, last_r;
  logic [KW-1:0]   k_idx_r;
  logic [SIZE-1:0] theta_r;

  logic            advance_s;
  logic [SIZE-1:0] flt_s;

  // The whole pipeline moves together unless a held output is refused
  assign advance_s = !(valid_r && !ready);

  // Run control: phase/index accumulation, busy and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      feed_r  <= 1'b0;
      k_r     <= '0;
      phase_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            feed_r  <= 1'b1;
            k_r     <= '0;
            phase_r <= '0;
          end
        end
        RUN: begin
          if (advance_s && feed_r) begin
            k_r     <= k_r + KW'(1);
            phase_r <= phase_r + STEP_Q;
            feed_r  <= (k_r != K_LAST);
          end
          if (valid_r && ready && last_r) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          feed_r  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the phase and index being issued this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_k_r     <= '0;
      s1_phase_r <= '0;
    end else if (advance_s) begin
      s1_valid_r <= feed_r;
      if (feed_r) begin
        s1_phase_r <= phase_r;
        s1_k_r     <= k_r;
        s1_last_r  <= (k_r == K_LAST);
      end
    end
  end

  fix2float #(.DOUBLE(DOUBLE)) u_fix2float (
    .fix (s1_phase_r),
    .flt (flt_s)
  );

  // Stage 2: register the converted angle onto the output interface
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      k_idx_r <= '0;
      theta_r <= '0;
    end else if (advance_s) begin
      valid_r <= s1_valid_r;
      last_r  <= s1_valid_r & s1_last_r;
      if (s1_valid_r) begin
        theta_r <= flt_s;
        k_idx_r <= s1_k_r;
      end
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign valid = valid_r;
  assign last  = last_r;
  assign k_idx = k_idx_r;
  assign theta = theta_r;

endmodule

// File: tb/tb_twiddle_angle_gen.sv
// Directed bench for twiddle_angle_gen: single precision N=16, double
// precision N=8 and the minimal N=4 configuration.
module tb_twiddle_angle_gen;

  localparam logic [31:0] EXP_SP [8] = '{
    32'h0000_0000, 32'hBEC9_0FDA, 32'hBF49_0FDA, 32'hBF96_CBE3,
    32'hBFC9_0FDA, 32'hBFFB_53D1, 32'hC016_CBE3, 32'hC02F_EDDF
  };
  localparam logic [63:0] EXP_DP [4] = '{
    64'h0000_0000_0000_0000, 64'hBFE9_21FB_5444_2D18,
    64'hBFF9_21FB_5444_2D18, 64'hC002_D97C_7F33_21D2
  };
  localparam logic [31:0] EXP_Q [2] = '{32'h0000_0000, 32'hBFC9_0FDA};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic start_a = 1'b0, ready_a = 1'b1;
  logic busy_a, valid_a, last_a, done_a;
  logic [31:0] theta_a;
  logic [2:0]  kidx_a;

  logic start_d = 1'b0, ready_d = 1'b1;
  logic busy_d, valid_d, last_d, done_d;
  logic [63:0] theta_d;
  logic [1:0]  kidx_d;

  logic start_q = 1'b0, ready_q = 1'b1;
  logic busy_q, valid_q, last_q, done_q;
  logic [31:0] theta_q;
  logic [0:0]  kidx_q;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  twiddle_angle_gen #(.DOUBLE(1'b0), .LOG2N(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .theta(theta_a),
    .k_idx(kidx_a), .valid(valid_a), .ready(ready_a), .last(last_a), .done(done_a)
  );

  twiddle_angle_gen #(.DOUBLE(1'b1), .LOG2N(3)) dut_d (
    .clk(clk), .rst(rst), .start(start_d), .busy(busy_d), .theta(theta_d),
    .k_idx(kidx_d), .valid(valid_d), .ready(ready_d), .last(last_d), .done(done_d)
  );

  twiddle_angle_gen #(.DOUBLE(1'b0), .LOG2N(2)) dut_q (
    .clk(clk), .rst(rst), .start(start_q), .busy(busy_q), .theta(theta_q),
    .k_idx(kidx_q), .valid(valid_q), .ready(ready_q), .last(last_q), .done(done_q)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec += 6;
    if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_a); end
    if (busy_a  !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_a); end
    if (done_a  !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done_a); end
    if (last_a  !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", last_a); end
    if (theta_a !== 32'h0) begin n_bad++; $display("FAIL reset_theta got %h want 0", theta_a); end
    if (kidx_a  !== 3'd0) begin n_bad++; $display("FAIL reset_kidx got %0d want 0", kidx_a); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    ready_a = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n_vec += 2;
    if (busy_a !== 1'b1) begin n_bad++; $display("FAIL stream_busy got %b want 1", busy_a); end
    if (valid_a !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid got %b want 0", valid_a); end
    @(negedge clk);
    n_vec++;
    if (valid_a !== 1'b0) begin n_bad++; $display("FAIL stream_latency got %b want 0", valid_a); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec += 4;
      if (valid_a !== 1'b1) begin n_bad++; $display("FAIL stream_valid k%0d got %b want 1", i, valid_a); end
      if (kidx_a !== 3'(i)) begin n_bad++; $display("FAIL stream_kidx got %0d want %0d", kidx_a, i); end
      if (theta_a !== EXP_SP[i]) begin n_bad++; $display("FAIL stream_theta k%0d got %h want %h", i, theta_a, EXP_SP[i]); end
      if (last_a !== (i == 7)) begin n_bad++; $display("FAIL stream_last k%0d got %b want %b", i, last_a, (i == 7)); end
    end
    @(negedge clk);
    n_vec += 4;
    if (done_a !== 1'b1) begin n_bad++; $display("FAIL stream_done got %b want 1", done_a); end
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL stream_busy_end got %b want 0", busy_a); end
    if (valid_a !== 1'b0) begin n_bad++; $display("FAIL stream_valid_end got %b want 0", valid_a); end
    if (last_a !== 1'b0) begin n_bad++; $display("FAIL stream_last_end got %b want 0", last_a); end
    @(negedge clk);
    n_vec++;
    if (done_a !== 1'b0) begin n_bad++; $display("FAIL stream_done_width got %b want 0", done_a); end
  endtask

  task automatic test_backpressure();
    int cnt = 0, dones = 0, stalls = 0;
    bit stall_used = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cnt > 0 && cnt < 8) begin
        n_vec++;
        if (valid_a !== 1'b1) begin n_bad++; $display("FAIL bp_gap after k%0d got valid %b want 1", cnt - 1, valid_a); end
      end
      if (!stall_used && valid_a && kidx_a == 3'd3) begin stall_used = 1'b1; stalls = 5; end
      if (stalls > 0) begin
        ready_a = 1'b0;
        stalls--;
        n_vec += 2;
        if (theta_a !== 32'hBF96_CBE3) begin n_bad++; $display("FAIL bp_hold_theta got %h want bf96cbe3", theta_a); end
        if (kidx_a !== 3'd3) begin n_bad++; $display("FAIL bp_hold_kidx got %0d want 3", kidx_a); end
      end else begin
        ready_a = 1'b1;
      end
      if (valid_a && ready_a) begin
        if (cnt < 8) begin
          n_vec += 2;
          if (kidx_a !== 3'(cnt)) begin n_bad++; $display("FAIL bp_order got %0d want %0d", kidx_a, cnt); end
          if (theta_a !== EXP_SP[cnt]) begin n_bad++; $display("FAIL bp_theta k%0d got %h want %h", cnt, theta_a, EXP_SP[cnt]); end
        end
        cnt++;
      end
      if (done_a) dones++;
    end
    ready_a = 1'b1;
    n_vec += 3;
    if (!stall_used) begin n_bad++; $display("FAIL bp_k3_seen got 0 want 1"); end
    if (cnt !== 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", cnt); end
    if (dones !== 1) begin n_bad++; $display("FAIL bp_done_count got %0d want 1", dones); end
  endtask

  task automatic test_restart_ignored();
    int cnt = 0, dones = 0;
    bit pulsed = 1'b0, chk_idle = 1'b0;
    ready_a = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (chk_idle) begin
        chk_idle = 1'b0;
        n_vec++;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL start_at_done got busy %b want 0", busy_a); end
      end
      if (valid_a && ready_a) begin
        if (cnt < 8) begin
          n_vec++;
          if (kidx_a !== 3'(cnt)) begin n_bad++; $display("FAIL restart_order got %0d want %0d", kidx_a, cnt); end
        end
        cnt++;
      end
      if (valid_a && kidx_a == 3'd2 && !pulsed) begin pulsed = 1'b1; start_a = 1'b1; end
      if (done_a) begin
        dones++;
        if (dones == 1) begin start_a = 1'b1; chk_idle = 1'b1; end
      end
    end
    start_a = 1'b0;
    n_vec += 2;
    if (cnt !== 8) begin n_bad++; $display("FAIL restart_count got %0d want 8", cnt); end
    if (dones !== 1) begin n_bad++; $display("FAIL restart_done_count got %0d want 1", dones); end
  endtask

  task automatic test_reset_midrun();
    bit hit = 1'b0;
    int dones = 0;
    ready_a = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
      @(negedge clk);
      if (valid_a && kidx_a == 3'd5) begin hit = 1'b1; rst = 1'b1; end
    end
    n_vec++;
    if (!hit) begin n_bad++; $display("FAIL midrun_reach_k5 got 0 want 1"); end
    @(negedge clk);
    rst = 1'b0;
    n_vec += 2;
    if (valid_a !== 1'b0) begin n_bad++; $display("FAIL midrun_valid got %b want 0", valid_a); end
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL midrun_busy got %b want 0", busy_a); end
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    n_vec++;
    if (dones !== 0) begin n_bad++; $display("FAIL midrun_no_done got %0d want 0", dones); end
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec += 3;
    if (valid_a !== 1'b1) begin n_bad++; $display("FAIL fresh_valid got %b want 1", valid_a); end
    if (kidx_a !== 3'd0) begin n_bad++; $display("FAIL fresh_kidx got %0d want 0", kidx_a); end
    if (theta_a !== 32'h0) begin n_bad++; $display("FAIL fresh_theta got %h want 0", theta_a); end
    repeat (14) @(negedge clk);
  endtask

  task automatic test_double();
    ready_d = 1'b1;
    @(negedge clk); start_d = 1'b1;
    @(negedge clk); start_d = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec += 4;
      if (valid_d !== 1'b1) begin n_bad++; $display("FAIL dp_valid k%0d got %b want 1", i, valid_d); end
      if (kidx_d !== 2'(i)) begin n_bad++; $display("FAIL dp_kidx got %0d want %0d", kidx_d, i); end
      if (theta_d !== EXP_DP[i]) begin n_bad++; $display("FAIL dp_theta k%0d got %h want %h", i, theta_d, EXP_DP[i]); end
      if (last_d !== (i == 3)) begin n_bad++; $display("FAIL dp_last k%0d got %b want %b", i, last_d, (i == 3)); end
    end
    @(negedge clk);
    n_vec += 2;
    if (done_d !== 1'b1) begin n_bad++; $display("FAIL dp_done got %b want 1", done_d); end
    if (valid_d !== 1'b0) begin n_bad++; $display("FAIL dp_valid_end got %b want 0", valid_d); end
    @(negedge clk);
  endtask

  task automatic test_log2n_2();
    ready_q = 1'b1;
    @(negedge clk); start_q = 1'b1;
    @(negedge clk); start_q = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec += 4;
      if (valid_q !== 1'b1) begin n_bad++; $display("FAIL n4_valid k%0d got %b want 1", i, valid_q); end
      if (kidx_q !== 1'(i)) begin n_bad++; $display("FAIL n4_kidx got %0d want %0d", kidx_q, i); end
      if (theta_q !== EXP_Q[i]) begin n_bad++; $display("FAIL n4_theta k%0d got %h want %h", i, theta_q, EXP_Q[i]); end
      if (last_q !== (i == 1)) begin n_bad++; $display("FAIL n4_last k%0d got %b want %b", i, last_q, (i == 1)); end
    end
    @(negedge clk);
    n_vec += 3;
    if (done_q !== 1'b1) begin n_bad++; $display("FAIL n4_done got %b want 1", done_q); end
    if (valid_q !== 1'b0) begin n_bad++; $display("FAIL n4_valid_end got %b want 0", valid_q); end
    if (busy_q !== 1'b0) begin n_bad++; $display("FAIL n4_busy_end got %b want 0", busy_q); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_restart_ignored();
    test_reset_midrun();
    test_double();
    test_log2n_2();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/twiddle_angle_gen.md
Name: twiddle_angle_gen

Overview:
- Upstream feeder for the `twiddle` block. For an N-point radix-2 FFT it emits the angle sequence theta_k = -2*pi*k/N, k = 0..N/2-1, as IEEE-754 values (single or double).
- Each output goes straight onto twiddle.theta.
- Phase is accumulated in unsigned fixed point, then normalised to floating point in a stall-able 2-stage pipeline.
- Output uses a valid/ready handshake so the downstream butterfly scheduler can throttle.

Parameters:
- double, 0, 0 = single precision (size = 32), 1 = double precision (size = 64); same meaning as in `twiddle`.
- LOG2N, 4, log2 of FFT length N; legal range 2..16; emits N/2 angles per run.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the cycle after the last handshake.
- theta  out  size  IEEE-754 angle, valid when valid=1.
- k_idx  out  LOG2N-1  twiddle index k of the current theta.
- valid  out  1  output holds a valid angle.
- ready  in  1  downstream accepts when valid and ready are both high.
- last  out  1  qualifies the k = N/2-1 output.
- done  out  1  one-cycle pulse in the cycle after the last handshake.

Behaviour:
- Reset: busy, valid, last, done = 0; theta, k_idx = 0; FSM = IDLE; pipeline flushed. Reset mid-run aborts immediately; no done pulse is generated.
- Fixed point:
  - W = size, FRAC = size-2 (Q2.FRAC).
  - PI_Q = round(pi*2^FRAC). For single this is 0xC90FDAA2.
  - STEP_Q = PI_Q >> (LOG2N-1), which truncates.
  - phase_k = k*STEP_Q, accumulated by adding STEP_Q. No multiplier. It never overflows because phase < pi < 4.
- Float conversion:
  - phase = 0 maps to +0.0 (all zeros).
  - Otherwise m = index of the leading one. sign = 1; biased exponent = m + (bias - FRAC), i.e. m+97 for single, m+961 for double.
  - Mantissa = bits below m, MSB-aligned into 23/52 bits. Truncate (no rounding) and zero-fill if too short.
- FSM:
  - IDLE --start--> RUN: k = 0, phase = 0, busy = 1.
  - RUN: a new phase enters the pipeline whenever the pipeline advances, until k = N/2-1 has entered. RUN --last handshake--> DONE.
  - DONE: done = 1 for one cycle, busy = 0, then -> IDLE.
- Pipeline:
  - Stage 1 registers phase and k. Stage 2 registers LZC plus normalised fields into the theta/k_idx/last/valid outputs.
  - Latency: start accepted at edge t gives valid=1 at edge t+2.
  - Throughput: 1 angle per cycle while ready=1.
- Stall rule: the pipeline advances iff !(valid && !ready). While stalled, theta, k_idx and last are held bit-stable.
- Boundaries:
  - start while busy: ignored, with no restart.
  - start in the same cycle as done: ignored; a new start is accepted from IDLE only.
  - ready high while valid is low: no effect.
  - LOG2N = 2: exactly 2 outputs, k = 0 and k = 1.

Decomposition:
- Shared package `fft_pkg`, holding:
  - size/FRAC/bias localparam functions of `double`;
  - PI_Q constants for both precisions;
  - exponent-offset constants;
  - the FSM state enum (IDLE, RUN, DONE).
- One sub-module `fix2float`: a combinational leading-zero count and normalise (W-bit Q2.FRAC unsigned in, sign forced 1, IEEE out). It is reusable elsewhere in the FFT.

Test Plan:
- Reset: assert rst for 3 cycles -> valid = busy = done = last = 0, theta = 0.
- Single precision, LOG2N = 4, ready tied to 1, start pulse:
  - 8 consecutive valid cycles starting 2 cycles after start; k_idx = 0..7.
  - k0 = 0x00000000; k1 = 0xBEC90FDA; k4 = 0xBFC90FDA; k7 = 0xC02FEDDF.
  - last only on k7; done pulses one cycle later.
- Backpressure: same run with ready = 0 for 5 cycles while k3 is presented -> theta stays 0xBF96CBE3 (-3pi/8, truncated), k_idx = 3 unchanged throughout. Then k4 follows immediately; the output sequence has no gaps or duplicates.
- start re-pulsed during the run at k = 2 -> ignored; exactly 8 outputs and one done.
- Reset mid-run at k = 5 -> next cycle valid = 0 and busy = 0; no done pulse. A fresh start restarts at k = 0.
- double = 1, LOG2N = 3: outputs match a bit-exact reference model of the fixed-point/truncation rules.
  - k0 = 0x0000000000000000.
  - k2 has sign 1, exponent 0x3FF, mantissa top bits 0x921FB54442D1.
  - Feed all outputs into a `twiddle` instance and check cos/sin to within 2 ulp.
